// File: rtl/md5_block_engine.sv
// md5_block_engine
//   MD5 compression engine. Absorbs 512-bit blocks as a valid/ready stream of
//   IN_WORDS 32-bit words per beat, runs the 64 RFC 1321 steps at
//   STEPS_PER_CYCLE steps per clock and chains blocks into a 128-bit digest.
//
// Parameters
//   IN_WORDS         words per input beat (1, 2, 4)
//   STEPS_PER_CYCLE  MD5 steps per clock (1, 2, 4)
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   dataVld/dataRdy  beat handshake; dataIn word i = X[beat*IN_WORDS+i]
//   msgFirst/msgLast sampled on the first beat of a block only
//   busy             high while computing or accumulating
//   msgDgstVld       one-cycle pulse when msgDigest is updated
//   msgDigest        {A,B,C,D}, A in [127:96]
//
// Configuration
//   MD5_BYTE_SWAP_EN  when defined, input words and digest words are
//                     byte-reversed (big-endian byte stream / canonical hex).
module md5_block_engine #(
  parameter int unsigned IN_WORDS        = 1,
  parameter int unsigned STEPS_PER_CYCLE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    dataVld,
  output logic                    dataRdy,
  input  logic [32*IN_WORDS-1:0]  dataIn,
  input  logic                    msgFirst,
  input  logic                    msgLast,
  output logic                    busy,
  output logic                    msgDgstVld,
  output logic [127:0]            msgDigest
);

  localparam int unsigned Beats    = 16 / IN_WORDS;
  localparam logic [3:0]  LastBeat = 4'(Beats - 1);
  localparam logic [5:0]  StepInc  = 6'(STEPS_PER_CYCLE);
  localparam logic [5:0]  LastStep = 6'(64 - STEPS_PER_CYCLE);
  localparam logic [127:0] Iv = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};

  localparam logic [31:0] KRom [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Indexed by {round, step[1:0]}
  localparam logic [4:0] STab [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21
  };

  typedef enum logic [1:0] {StLoad, StCompute, StAccum} state_e;

  state_e       state;
  logic [3:0]   beatCnt;
  logic [5:0]   stepCnt;
  logic [31:0]  xBuf [16];
  logic [127:0] hReg;      // chaining value {A,B,C,D}
  logic [127:0] work;      // working registers {A,B,C,D}
  logic         lastBlk;
  logic [127:0] workNext;
  logic [127:0] hSum;

  function automatic logic [31:0] bswap(input logic [31:0] w);
`ifdef MD5_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] v, input logic [4:0] s);
    return (v << s) | (v >> (6'd32 - {1'b0, s}));
  endfunction

  function automatic logic [3:0] msgIdx(input logic [5:0] i);
    logic [3:0] g;
    case (i[5:4])
      2'd0:    g = i[3:0];
      2'd1:    g = i[3:0] * 4'd5 + 4'd1;
      2'd2:    g = i[3:0] * 4'd3 + 4'd5;
      default: g = i[3:0] * 4'd7;
    endcase
    return g;
  endfunction

  function automatic logic [127:0] md5Step(input logic [127:0] st, input logic [5:0] i,
                                           input logic [31:0] xw);
    logic [31:0] a, b, c, d, f, sum;
    {a, b, c, d} = st;
    case (i[5:4])
      2'd0:    f = (b & c) | (~b & d);
      2'd1:    f = (d & b) | (~d & c);
      2'd2:    f = b ^ c ^ d;
      default: f = c ^ (b | ~d);
    endcase
    sum = a + f + KRom[i] + xw;
    return {d, b + rotl(sum, STab[{i[5:4], i[1:0]}]), b, c};
  endfunction

  // STEPS_PER_CYCLE steps chained combinationally from the current step index
  always_comb begin
    workNext = work;
    for (int j = 0; j < int'(STEPS_PER_CYCLE); j++) begin
      workNext = md5Step(workNext, stepCnt + 6'(j), xBuf[msgIdx(stepCnt + 6'(j))]);
    end
  end

  assign hSum = {hReg[127:96] + work[127:96], hReg[95:64] + work[95:64],
                 hReg[63:32] + work[63:32], hReg[31:0] + work[31:0]};

  assign dataRdy = (state == StLoad);
  assign busy    = (state != StLoad);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StLoad;
      beatCnt    <= '0;
      stepCnt    <= '0;
      hReg       <= Iv;
      work       <= '0;
      lastBlk    <= 1'b0;
      msgDigest  <= '0;
      msgDgstVld <= 1'b0;
      for (int i = 0; i < 16; i++) xBuf[i] <= '0;
    end else begin
      msgDgstVld <= 1'b0;
      case (state)
        StLoad: begin
          if (dataVld) begin
            for (int i = 0; i < int'(IN_WORDS); i++) begin
              xBuf[4'(int'(beatCnt) * int'(IN_WORDS) + i)] <= bswap(dataIn[32*i +: 32]);
            end
            if (beatCnt == '0) begin
              lastBlk <= msgLast;
              // msgFirst overrides any chained value
              if (msgFirst) begin
                hReg <= Iv;
                work <= Iv;
              end else begin
                work <= hReg;
              end
            end
            if (beatCnt == LastBeat) begin
              beatCnt <= '0;
              state   <= StCompute;
            end else begin
              beatCnt <= beatCnt + 4'd1;
            end
          end
        end
        StCompute: begin
          work    <= workNext;
          stepCnt <= stepCnt + StepInc;  // wraps to 0 after the final step
          if (stepCnt == LastStep) state <= StAccum;
        end
        StAccum: begin
          state <= StLoad;
          if (lastBlk) begin
            // Message done: emit and re-arm so the next block starts fresh
            hReg       <= Iv;
            msgDigest  <= {bswap(hSum[127:96]), bswap(hSum[95:64]),
                           bswap(hSum[63:32]), bswap(hSum[31:0])};
            msgDgstVld <= 1'b1;
          end else begin
            hReg <= hSum;
          end
        end
        default: state <= StLoad;
      endcase
    end
  end

endmodule

// File: doc/md5_block_engine.md
# md5_block_engine

Self-contained, parametrised MD5 compression engine: it absorbs 512-bit message blocks over a valid/ready word stream, runs the 64 MD5 steps at a configurable number of steps per clock, and chains blocks into a 128-bit digest. It is the next-generation replacement for the split control, combinational and external adder/register-file MD5 datapath. All state, the round constants, the shift table and the adders are internal. It sits between the message padder (upstream) and the digest consumer (downstream).

## Interface
- `IN_WORDS`, default 1: 32-bit words per input beat. Legal values: 1, 2, 4.
- `STEPS_PER_CYCLE`, default 1: MD5 steps evaluated per clock. Legal values: 1, 2, 4.
- `clk` input 1: rising-edge clock, sole clock domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `dataVld` input 1: beat valid.
- `dataRdy` output 1: engine accepts a beat when `dataVld & dataRdy`.
- `dataIn` input 32*IN_WORDS: message words; bits [32i+31:32i] hold word X[k*IN_WORDS+i] of beat k.
- `msgFirst` input 1: sampled on the first beat of a block; the block starts a new message.
- `msgLast` input 1: sampled on the first beat of a block; the block ends the message.
- `busy` output 1: high in COMPUTE and ACCUM.
- `msgDgstVld` output 1: one-cycle digest-valid pulse.
- `msgDigest` output 128: {A,B,C,D}; [127:96] = A.

## Operation
- States:
  - LOAD: dataRdy=1. Collect 16/IN_WORDS beats into the 16x32 X buffer, then go to COMPUTE.
  - COMPUTE: step counter 0..63 advances by STEPS_PER_CYCLE. After the 64th step, go to ACCUM.
  - ACCUM: H += {A,B,C,D}, modulo 2^32 per word. If the block carried msgLast, load msgDigest and pulse msgDgstVld. Return to LOAD.
- First beat of a block:
  - If msgFirst=1, H is set to IV (67452301, efcdab89, 98badcfe, 10325476), overriding any chained value.
  - Working registers A..D are loaded from the (possibly reset) H.
- After an msgLast block completes, H reverts to IV automatically. A following block without msgFirst therefore still starts a fresh message.
- Step arithmetic follows RFC 1321:
  - Step i: F/G/H/I selected by i[5:4]; K[i] from a 64-entry constant ROM; rotate amount from the s-table; message index g per round.
  - All additions are 32-bit and wrap.
  - Multiple steps per cycle are chained combinationally inside one clock.
- msgFirst and msgLast on beats other than the first of a block are ignored. Both set on the same block means a single-block message.
- Backpressure: when dataRdy=0, dataVld is ignored. The source holds data; nothing is buffered.
- Reset values: state=LOAD, beat counter=0, step counter=0, H=IV, A..D=0, msgDigest=0, msgDgstVld=0, busy=0. dataRdy reads 1 during reset, but no beat is captured while rst_n=0.
- Reset mid-block or mid-compute: the partial block is discarded, no msgDgstVld pulse, and the previous msgDigest is cleared to 0.

## Timing
- Last beat accepted at edge t. COMPUTE spans cycles t+1 .. t+64/STEPS_PER_CYCLE. ACCUM occupies cycle t+64/STEPS_PER_CYCLE+1.
- msgDgstVld is high exactly one cycle, at t+64/STEPS_PER_CYCLE+2. msgDigest is stable from that cycle until the next digest.
- dataRdy rises in the same cycle msgDgstVld would appear: the engine is in LOAD one cycle after ACCUM.
- Block period = 16/IN_WORDS + 64/STEPS_PER_CYCLE + 1 cycles. Defaults: 81.
- dataRdy and busy are pure decodes of registered state and do not depend combinationally on dataVld.

## Configuration
- `MD5_BYTE_SWAP_EN`:
  - Defined: each 32-bit input word is byte-reversed before storage, so byte-stream big-endian packing yields MD5 little-endian words. Each digest word is also byte-reversed, so msgDigest reads as the canonical hex string.
  - Undefined: words are used and emitted as numeric little-endian MD5 words, with no swapping.

## Test plan
- Empty message, swap off, defaults: one block with msgFirst=msgLast=1, X0=00000080, rest 0 -> at t+66, msgDigest = d98c1dd4_04b2008f_980980e9_7e42f8ec with a single-cycle msgDgstVld pulse.
- "abc", swap off: X0=80636261, X14=00000018 -> msgDigest = 98500190_b04fd23c_7d3f96d6_727fe128. Repeat with STEPS_PER_CYCLE=4 and IN_WORDS=4: same digest, msgDgstVld at t+18, block period 21.
- "abc" with MD5_BYTE_SWAP_EN defined, X0=61626380 -> msgDigest = 900150983cd24fb0d6963f7d28e17f72.
- Two back-to-back empty-message blocks, the second without msgFirst -> both give the empty digest, proving H auto-reverts to IV. Hold dataVld high while busy -> no beats consumed.
- Two-block message (56 'a' bytes, padded to two blocks), with msgDgstVld checked low after block 1 -> digest matches the reference model. The intermediate H must not be emitted.
- Assert rst_n low mid-COMPUTE, then resend "abc" -> no pulse for the aborted block, msgDigest=0 after reset, and the correct "abc" digest follows.
